// File: rtl/comparador_secuencial_param_if.sv
// rtl/comparador_secuencial_param_if.sv - start/operand/result bundle for the chunked sequential comparator
interface comparador_secuencial_param_if #(
    parameter int ANCHO = 6
);
    logic             inicio;
    logic             consigno;
    logic [ANCHO-1:0] entrada_a;
    logic [ANCHO-1:0] entrada_b;
    logic             ocupado;
    logic             listo;
    logic             mayor;
    logic             igual;
    logic             menor;

    modport master (
        output inicio, consigno, entrada_a, entrada_b,
        input  ocupado, listo, mayor, igual, menor
    );

    modport slave (
        input  inicio, consigno, entrada_a, entrada_b,
        output ocupado, listo, mayor, igual, menor
    );
endinterface

// File: rtl/comparador_secuencial_param.sv
// rtl/comparador_secuencial_param.sv - MSB-first comparator examining PASO bits per cycle with early exit
module comparador_secuencial_param #(
    parameter int ANCHO = 6,
    parameter int PASO  = 2
) (
    input  logic                          reloj,
    input  logic                          reset_n,
    comparador_secuencial_param_if.slave  bus
);
    localparam int N  = ANCHO / PASO;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] COMPARA = 2'd1;
    localparam logic [1:0] FIN     = 2'd2;

    logic [1:0]       estado;
    logic [IW-1:0]    indice;
    logic [ANCHO-1:0] reg_a;
    logic [ANCHO-1:0] reg_b;
    logic             res_mayor;
    logic             res_igual;
    logic             res_menor;

    logic [ANCHO-1:0] mascara_signo;
    logic [PASO-1:0]  trozo_a;
    logic [PASO-1:0]  trozo_b;
    logic             ultimo;

    // Flipping the sign bit maps two's complement onto offset binary, so an
    // unsigned chunk compare then orders signed operands correctly.
    assign mascara_signo = {bus.consigno, {(ANCHO-1){1'b0}}};

    // Operands are shifted left after each equal chunk, so the chunk under
    // test always sits in the top PASO bits.
    assign trozo_a = reg_a[ANCHO-1 -: PASO];
    assign trozo_b = reg_b[ANCHO-1 -: PASO];
    assign ultimo  = (indice == IW'(N - 1));

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= REPOSO;
            indice    <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            res_mayor <= 1'b0;
            res_igual <= 1'b0;
            res_menor <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.inicio) begin
                        reg_a  <= bus.entrada_a ^ mascara_signo;
                        reg_b  <= bus.entrada_b ^ mascara_signo;
                        indice <= '0;
                        estado <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (trozo_a > trozo_b) begin
                        res_mayor <= 1'b1;
                        res_igual <= 1'b0;
                        res_menor <= 1'b0;
                        estado    <= FIN;
                    end else if (trozo_a < trozo_b) begin
                        res_mayor <= 1'b0;
                        res_igual <= 1'b0;
                        res_menor <= 1'b1;
                        estado    <= FIN;
                    end else if (ultimo) begin
                        res_mayor <= 1'b0;
                        res_igual <= 1'b1;
                        res_menor <= 1'b0;
                        estado    <= FIN;
                    end else begin
                        reg_a  <= reg_a << PASO;
                        reg_b  <= reg_b << PASO;
                        indice <= indice + IW'(1);
                    end
                end
                FIN: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    assign bus.ocupado = (estado == COMPARA) || (estado == FIN);
    assign bus.listo   = (estado == FIN);
    assign bus.mayor   = res_mayor;
    assign bus.igual   = res_igual;
    assign bus.menor   = res_menor;
endmodule

// File: tb/tb_comparador_secuencial_param.sv
// tb/tb_comparador_secuencial_param.sv - scoreboard bench for the sequential comparator (6/2 and 8/1)
module tb_comparador_secuencial_param;
    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;

    localparam logic [2:0] R_MAYOR = 3'b100;
    localparam logic [2:0] R_IGUAL = 3'b010;
    localparam logic [2:0] R_MENOR = 3'b001;

    logic clk;
    logic rst_n;
    int   cyc;
    int   compared;
    int   mismatched;

    exp_t       q6[$];
    exp_t       q8[$];
    logic [2:0] last6;
    logic [2:0] last8;

    comparador_secuencial_param_if #(.ANCHO(6)) bus6 ();
    comparador_secuencial_param_if #(.ANCHO(8)) bus8 ();

    comparador_secuencial_param #(.ANCHO(6), .PASO(2)) dut6 (
        .reloj   (clk),
        .reset_n (rst_n),
        .bus     (bus6.slave)
    );

    comparador_secuencial_param #(.ANCHO(8), .PASO(1)) dut8 (
        .reloj   (clk),
        .reset_n (rst_n),
        .bus     (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation on every Listo pulse, otherwise checks the
    // result flags still hold the last expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last6 = 3'b000;
            last8 = 3'b000;
        end else begin
            if (bus6.listo) begin
                if (q6.size() == 0) begin
                    chk("listo6_unexpected", 1, 0);
                end else begin
                    e = q6.pop_front();
                    chk("res6", {bus6.mayor, bus6.igual, bus6.menor}, e.res);
                    chk("lat6", cyc, e.cyc);
                    last6 = e.res;
                end
            end else begin
                chk("hold6", {bus6.mayor, bus6.igual, bus6.menor}, last6);
            end
            if (bus8.listo) begin
                if (q8.size() == 0) begin
                    chk("listo8_unexpected", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("res8", {bus8.mayor, bus8.igual, bus8.menor}, e.res);
                    chk("lat8", cyc, e.cyc);
                    last8 = e.res;
                end
            end else begin
                chk("hold8", {bus8.mayor, bus8.igual, bus8.menor}, last8);
            end
        end
    end

    task automatic wait_idle6();
        bit done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!bus6.ocupado) done = 1;
        end
        chk("idle6_timeout", done, 1);
        #1;
    endtask

    task automatic wait_idle8();
        bit done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!bus8.ocupado) done = 1;
        end
        chk("idle8_timeout", done, 1);
        #1;
    endtask

    // Called away from the clock edge; the next rising edge is E0 and the
    // result is expected after edge E0+lat.
    task automatic start6(input logic [5:0] a, input logic [5:0] b, input logic s,
                          input logic [2:0] res, input int lat);
        bus6.entrada_a = a;
        bus6.entrada_b = b;
        bus6.consigno  = s;
        bus6.inicio    = 1'b1;
        q6.push_back('{res, cyc + 1 + lat});
        @(posedge clk);
        #1 bus6.inicio = 1'b0;
        wait_idle6();
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [2:0] res, input int lat);
        bus8.entrada_a = a;
        bus8.entrada_b = b;
        bus8.consigno  = s;
        bus8.inicio    = 1'b1;
        q8.push_back('{res, cyc + 1 + lat});
        @(posedge clk);
        #1 bus8.inicio = 1'b0;
        wait_idle8();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus6.inicio = 1'b0; bus6.consigno = 1'b0; bus6.entrada_a = '0; bus6.entrada_b = '0;
        bus8.inicio = 1'b0; bus8.consigno = 1'b0; bus8.entrada_a = '0; bus8.entrada_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ocupado6", bus6.ocupado, 0);
        chk("rst_listo6", bus6.listo, 0);
        chk("rst_flags6", {bus6.mayor, bus6.igual, bus6.menor}, 0);
        chk("rst_flags8", {bus8.ocupado, bus8.listo, bus8.mayor, bus8.igual, bus8.menor}, 0);
        rst_n = 1'b1;

        // First edge after reset release accepts the start request.
        start6(6'b110000, 6'b010000, 1'b0, R_MAYOR, 1);
        start6(6'b110000, 6'b010000, 1'b1, R_MENOR, 1);
        start6(6'd37,     6'd37,     1'b0, R_IGUAL, 3);
        start6(6'd37,     6'd37,     1'b1, R_IGUAL, 3);
        start6(6'b000011, 6'b000010, 1'b0, R_MAYOR, 3);
        start6(6'd5,      6'd9,      1'b0, R_MENOR, 2);
        start6(6'b111111, 6'b000001, 1'b1, R_MENOR, 1);
        start6(6'b111101, 6'b111011, 1'b1, R_MAYOR, 2);
        start6(6'd0,      6'd63,     1'b0, R_MENOR, 1);

        // Second start with new operands/mode while busy must be ignored.
        bus6.entrada_a = 6'd37;
        bus6.entrada_b = 6'd37;
        bus6.consigno  = 1'b0;
        bus6.inicio    = 1'b1;
        q6.push_back('{R_IGUAL, cyc + 1 + 3});
        @(posedge clk);
        #1;
        bus6.entrada_a = 6'd0;
        bus6.entrada_b = 6'd63;
        bus6.consigno  = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus6.inicio = 1'b0;
        wait_idle6();

        // Reset in the middle of a comparison: aborted without Listo.
        bus6.entrada_a = 6'd37;
        bus6.entrada_b = 6'd37;
        bus6.consigno  = 1'b0;
        bus6.inicio    = 1'b1;
        @(posedge clk);
        #1 bus6.inicio = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ocupado", bus6.ocupado, 0);
        chk("midrst_listo", bus6.listo, 0);
        chk("midrst_flags", {bus6.mayor, bus6.igual, bus6.menor}, 0);
        @(posedge clk);
        #1;
        chk("midrst_held", {bus6.ocupado, bus6.listo, bus6.mayor, bus6.igual, bus6.menor}, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        start6(6'd5, 6'd9, 1'b0, R_MENOR, 2);

        start8(8'h80, 8'h7F, 1'b0, R_MAYOR, 1);
        start8(8'h80, 8'h7F, 1'b1, R_MENOR, 1);
        start8(8'hA5, 8'hA5, 1'b0, R_IGUAL, 8);
        start8(8'h01, 8'h00, 1'b0, R_MAYOR, 8);
        start8(8'hFE, 8'hFF, 1'b1, R_MENOR, 8);

        repeat (3) @(negedge clk);
        #1;
        chk("q6_drained", q6.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
